// File: rtl/lbus_axis_pkg.sv
// Shared AXI4-Stream definitions for the lbus path: bus widths, arbiter state type
// and the modulo-wrap helper used for rotating-priority index arithmetic.
package lbus_axis_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Operands are always below 2*n, so one conditional subtract is an exact modulo.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational rotating-priority picker: returns the requester with the smallest
// distance from start (wrapping), and whether any request was present.
module axis_rr_picker
  import lbus_axis_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

  // Scan from the farthest distance inward so the nearest requester is written last.
  always_comb begin
    int pos;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = rr_wrap(int'(start) + k, NUM_PORTS);
      if (req[pos]) begin
        idx   = IDX_W'(pos);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream egress between NUM_PORTS
// sources. Define ARB_PKT_CNT_EN to add per-port tlast-handshake counters on pkt_cnt.
module axis_pkt_arbiter
  import lbus_axis_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = AXIS_DATA_W,
  parameter int CNT_W     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_W-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_W-1:0]               m_axis_tdata,
  output logic [DATA_W/8-1:0]             m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
`ifdef ARB_PKT_CNT_EN
  output logic [NUM_PORTS*CNT_W-1:0]      pkt_cnt,
`endif
  output logic                            busy
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
    $error("axis_pkt_arbiter: NUM_PORTS must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("axis_pkt_arbiter: CNT_W must be at least 1");
  end

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   busy_q, busy_d;
  logic                   lock_s, hs_s, eop_s;
  logic [NUM_PORTS-1:0]   req_s;
  logic [IDX_W-1:0]       start_s, pick_idx_s;
  logic                   pick_found_s;

  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign start_s  = IDX_W'(rr_wrap(int'(last_grant_q) + 1, NUM_PORTS));

  // Zero-latency egress mux and per-port ready; the current grant is masked out of req.
  always_comb begin
    lock_s        = (state_q == ARB_LOCK);
    m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
    m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
    m_axis_tlast  = s_axis_tlast[grant_q];
    m_axis_tvalid = lock_s & s_axis_tvalid[grant_q];
    hs_s          = m_axis_tvalid & m_axis_tready;
    eop_s         = hs_s & m_axis_tlast;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_axis_tready[i] = lock_s & (grant_q == IDX_W'(i)) & m_axis_tready;
      req_s[i]         = s_axis_tvalid[i] & ~(lock_s & (grant_q == IDX_W'(i)));
    end
  end

  axis_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req   (req_s),
    .start (start_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Next-state: acquire from IDLE, or hand over on the tlast handshake without a bubble.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_d      = ARB_LOCK;
          grant_d      = pick_idx_s;
          last_grant_d = pick_idx_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCK: begin
        if (eop_s && pick_found_s) begin
          state_d      = ARB_LOCK;
          grant_d      = pick_idx_s;
          last_grant_d = pick_idx_s;
        end else if (eop_s) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_LOCK;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d == ARB_LOCK);
  end

  // Arbiter state, grant pointers and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ARB_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] cnt_d [NUM_PORTS];

  // Count completed packets per port; wraps naturally at 2^CNT_W.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, (eop_s && (grant_q == IDX_W'(i)))};
      pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
